// File: rtl/dbus_wb_master_if.sv
// Wishbone B4 classic bus bundle for the data-side master.
// Signal names keep the master's point of view (_o driven by master, _i by slave).
interface dbus_wb_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/dbus_wb_master.sv
// dbus_wb_master: turns the rv32i MEM-stage load/store request into one
// Wishbone B4 classic cycle, stalls the pipeline until it completes and
// returns lane-extracted, sign/zero-extended load data.
// Optional feature macro: DBUS_WB_TIMEOUT_EN adds a BUS-state watchdog that
// ends a silent access after TIMEOUT_CYCLES cycles as if the slave had erred.
module dbus_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             mem_addr_mem,
  input  logic [31:0]             mem_wdata_mem,
  input  logic                    mem_write_mem,
  input  logic                    mem_read_mem,
  input  logic [2:0]              mem_op_mem,
  output logic [31:0]             mem_rdata_mem,
  output logic                    stall_pipl,
  output logic                    bus_err_o,
  output logic                    misaligned_o,
  dbus_wb_master_if.master        wb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        bus_err_q, bus_err_d;
  logic        mis_q, mis_d;
  logic        req_s;
  logic        timeout_s;

  // Unsupported funct3 codes count as misaligned so they never reach the bus.
  function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic bad;
    case (op)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = (off != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] f_sel(input logic [2:0] op, input logic [1:0] off);
    logic [3:0] sel;
    case (op[1:0])
      2'b00:   sel = 4'b0001 << off;
      2'b01:   sel = 4'b0011 << off;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Narrow stores are replicated so every selected lane sees the right byte.
  function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] w);
    logic [31:0] d;
    case (op[1:0])
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] off,
                                         input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{off, 3'b000} +: 8];
    h = d[{off[1], 4'b0000} +: 16];
    case (op)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef DBUS_WB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 32'd256) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Watchdog count: zero outside BUS, so it starts at 0 on every BUS entry.
  always_comb begin
    tmo_d     = {TMO_W{1'b0}};
    timeout_s = 1'b0;
    if (state_q == ST_BUS) begin
      tmo_d     = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
      timeout_s = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 32'd1));
    end else begin
      tmo_d     = {TMO_W{1'b0}};
      timeout_s = 1'b0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= {TMO_W{1'b0}};
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  assign req_s      = mem_read_mem | mem_write_mem;
  assign stall_pipl = ((state_q == ST_IDLE) & req_s) | (state_q == ST_BUS);

  // Next-state and next-register logic for the IDLE -> BUS -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    op_d      = op_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    cyc_d     = 1'b0;
    bus_err_d = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s && f_misaligned(mem_op_mem, mem_addr_mem[1:0])) begin
          state_d = ST_DONE;
          rdata_d = 32'd0;
          mis_d   = 1'b1;
        end else if (req_s) begin
          state_d = ST_BUS;
          adr_d   = {mem_addr_mem[31:2], 2'b00};
          we_d    = mem_write_mem;
          sel_d   = f_sel(mem_op_mem, mem_addr_mem[1:0]);
          dat_d   = f_wdata(mem_op_mem, mem_wdata_mem);
          op_d    = mem_op_mem;
          off_d   = mem_addr_mem[1:0];
          cyc_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // err wins over ack; the watchdog only fires on a silent slave.
        if (wb.wb_err_i || (timeout_s && !wb.wb_ack_i)) begin
          state_d   = ST_DONE;
          rdata_d   = 32'd0;
          bus_err_d = 1'b1;
        end else if (wb.wb_ack_i) begin
          state_d = ST_DONE;
          rdata_d = we_q ? 32'd0 : f_load(op_q, off_q, wb.wb_dat_i);
        end else begin
          cyc_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      sel_q     <= 4'd0;
      we_q      <= 1'b0;
      op_q      <= 3'd0;
      off_q     <= 2'd0;
      rdata_q   <= 32'd0;
      cyc_q     <= 1'b0;
      bus_err_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      op_q      <= op_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      cyc_q     <= cyc_d;
      bus_err_q <= bus_err_d;
      mis_q     <= mis_d;
    end
  end

  assign wb.wb_adr_o   = adr_q;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_sel_o   = sel_q;
  assign wb.wb_we_o    = we_q;
  assign wb.wb_cyc_o   = cyc_q;
  assign wb.wb_stb_o   = cyc_q;
  assign mem_rdata_mem = rdata_q;
  assign bus_err_o     = bus_err_q;
  assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_dbus_wb_master.sv
// Randomized bench for dbus_wb_master with a transaction-level reference model.
module tb_dbus_wb_master;
  localparam int TB_TMO = 16;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr_mem, mem_wdata_mem, mem_rdata_mem;
  logic        mem_write_mem, mem_read_mem, stall_pipl, bus_err_o, misaligned_o;
  logic [2:0]  mem_op_mem;

  dbus_wb_master_if wb_if ();

  dbus_wb_master #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr_mem  (mem_addr_mem),
    .mem_wdata_mem (mem_wdata_mem),
    .mem_write_mem (mem_write_mem),
    .mem_read_mem  (mem_read_mem),
    .mem_op_mem    (mem_op_mem),
    .mem_rdata_mem (mem_rdata_mem),
    .stall_pipl    (stall_pipl),
    .bus_err_o     (bus_err_o),
    .misaligned_o  (misaligned_o),
    .wb            (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Expected values for the current cycle, set by the stimulus process.
  bit          e_chk = 1'b0;
  bit          e_stall, e_cyc, e_bus, e_we, e_err, e_mis;
  logic [31:0] e_adr, e_dat, e_rdata;
  logic [3:0]  e_sel;
  logic [31:0] last_rdata = 32'd0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int size_bytes(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_mis(input logic [2:0] op, input logic [31:0] addr);
    int n = size_bytes(op);
    if (n == 0) return 1'b1;
    return (addr % n) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [2:0] op, input logic [31:0] addr);
    int n = size_bytes(op);
    int v = ((1 << n) - 1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdat(input logic [2:0] op, input logic [31:0] w);
    int n = size_bytes(op);
    if (n == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] d);
    int n = size_bytes(op);
    logic [63:0] v;
    v = ({32'd0, d} >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 64'd1);
    if (op[2] == 1'b0 && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // Per-cycle comparison of DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (e_chk) begin
      cmp("stall", {31'd0, stall_pipl}, {31'd0, e_stall});
      cmp("cyc", {31'd0, wb_if.wb_cyc_o}, {31'd0, e_cyc});
      cmp("stb", {31'd0, wb_if.wb_stb_o}, {31'd0, e_cyc});
      cmp("rdata", mem_rdata_mem, e_rdata);
      cmp("bus_err", {31'd0, bus_err_o}, {31'd0, e_err});
      cmp("misaligned", {31'd0, misaligned_o}, {31'd0, e_mis});
      if (e_bus) begin
        cmp("adr", wb_if.wb_adr_o, e_adr);
        cmp("sel", {28'd0, wb_if.wb_sel_o}, {28'd0, e_sel});
        cmp("we", {31'd0, wb_if.wb_we_o}, {31'd0, e_we});
        cmp("dat_o", wb_if.wb_dat_o, e_dat);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spurious();
    wb_if.wb_ack_i = ($urandom_range(0, 3) == 0);
    wb_if.wb_err_i = ($urandom_range(0, 5) == 0);
    wb_if.wb_dat_i = $urandom;
  endtask

  task automatic exp_plain(input bit st);
    e_stall = st; e_cyc = 1'b0; e_bus = 1'b0;
    e_rdata = last_rdata; e_err = 1'b0; e_mis = 1'b0;
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [3:0] s, input bit w,
                         input logic [31:0] d);
    e_stall = 1'b1; e_cyc = 1'b1; e_bus = 1'b1;
    e_adr = a; e_sel = s; e_we = w; e_dat = d;
    e_rdata = last_rdata; e_err = 1'b0; e_mis = 1'b0;
  endtask

  task automatic exp_reset();
    exp_plain(1'b0);
    e_rdata = 32'd0; e_bus = 1'b1;
    e_adr = 32'd0; e_sel = 4'd0; e_we = 1'b0; e_dat = 32'd0;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] w, input bit wr,
                         input bit rd, input logic [2:0] op);
    mem_addr_mem = a; mem_wdata_mem = w;
    mem_write_mem = wr; mem_read_mem = rd; mem_op_mem = op;
  endtask

  task automatic idle_cycle();
    step();
    set_req($urandom, $urandom, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
    spurious();
    exp_plain(1'b0);
  endtask

  // One full access: IDLE detect, BUS with 'waits' wait states, DONE.
  task automatic run_access(input logic [31:0] a, input logic [31:0] w, input bit wr,
                            input bit rd, input logic [2:0] op, input int waits,
                            input bit err, input bit errack, input bit silent,
                            input logic [31:0] sdat, output int stalls);
    logic [31:0] res;
    stalls = 0;
    step();
    set_req(a, w, wr, rd, op);
    spurious();
    exp_plain(1'b1);
    #1 stalls += int'(stall_pipl);
    if (m_mis(op, a)) begin
      step();
      spurious();
      exp_plain(1'b0);
      e_rdata = 32'd0; e_mis = 1'b1;
      last_rdata = 32'd0;
      #1 stalls += int'(stall_pipl);
    end else begin
      for (int b = 0; b <= waits; b++) begin
        step();
        if (b == waits && !silent) begin
          wb_if.wb_ack_i = !err || errack;
          wb_if.wb_err_i = err;
          wb_if.wb_dat_i = sdat;
        end else begin
          wb_if.wb_ack_i = 1'b0;
          wb_if.wb_err_i = 1'b0;
          wb_if.wb_dat_i = $urandom;
        end
        exp_bus(a & ~32'd3, m_sel(op, a), wr, m_wdat(op, w));
        #1 stalls += int'(stall_pipl);
      end
      step();
      spurious();
      res = (err || silent) ? 32'd0 : (wr ? 32'd0 : m_load(op, a, sdat));
      exp_plain(1'b0);
      e_rdata = res; e_err = err || silent;
      last_rdata = res;
      #1 stalls += int'(stall_pipl);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int st;
    logic [2:0] ops [8];
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    reset = 1'b1;
    set_req(32'd0, 32'd0, 1'b0, 1'b0, 3'd0);
    wb_if.wb_ack_i = 1'b0; wb_if.wb_err_i = 1'b0; wb_if.wb_dat_i = 32'd0;
    step();
    exp_reset();
    e_chk = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_plain(1'b0);
    idle_cycle();

    // LW 0x100, zero-wait ack
    run_access(32'h100, 32'd0, 1'b0, 1'b1, 3'd2, 0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, st);
    cmp("lw_stall_cycles", st, 32'd2);
    cmp("lw_rdata_lit", mem_rdata_mem, 32'hDEADBEEF);
    // LB / LBU at 0x103, back-to-back
    run_access(32'h103, 32'd0, 1'b0, 1'b1, 3'd0, 0, 1'b0, 1'b0, 1'b0, 32'h80FF_0000, st);
    cmp("lb_rdata_lit", mem_rdata_mem, 32'hFFFF_FF80);
    run_access(32'h103, 32'd0, 1'b0, 1'b1, 3'd4, 1, 1'b0, 1'b0, 1'b0, 32'h80FF_0000, st);
    cmp("lbu_rdata_lit", mem_rdata_mem, 32'h0000_0080);
    // SH 0x202 with 3 wait states
    run_access(32'h202, 32'h0000_ABCD, 1'b1, 1'b0, 3'd1, 3, 1'b0, 1'b0, 1'b0, 32'h1234_5678, st);
    cmp("sh_stall_cycles", st, 32'd5);
    cmp("sh_dat_lit", wb_if.wb_dat_o, 32'hABCD_ABCD);
    cmp("sh_sel_lit", {28'd0, wb_if.wb_sel_o}, 32'h0000_000C);
    cmp("sh_adr_lit", wb_if.wb_adr_o, 32'h0000_0200);
    cmp("sh_rdata_lit", mem_rdata_mem, 32'd0);
    // misaligned LW 0x101
    run_access(32'h101, 32'd0, 1'b0, 1'b1, 3'd2, 0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, st);
    cmp("mis_stall_cycles", st, 32'd1);
    cmp("mis_pulse_lit", {31'd0, misaligned_o}, 32'd1);
    cmp("mis_rdata_lit", mem_rdata_mem, 32'd0);
    // SW with err and ack together
    run_access(32'h44, 32'h5555_AAAA, 1'b1, 1'b1, 3'd2, 1, 1'b1, 1'b1, 1'b0, 32'h0, st);
    cmp("err_pulse_lit", {31'd0, bus_err_o}, 32'd1);
    cmp("err_cyc_lit", {31'd0, wb_if.wb_cyc_o}, 32'd0);
    idle_cycle();

    // reset in the middle of a BUS cycle, then a late ack in IDLE
    run_access(32'h10, 32'd0, 1'b0, 1'b1, 3'd0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_00C3, st);
    step();
    set_req(32'h300, 32'h0BAD_F00D, 1'b0, 1'b1, 3'd2);
    spurious();
    exp_plain(1'b1);
    step();
    wb_if.wb_ack_i = 1'b0; wb_if.wb_err_i = 1'b0;
    exp_bus(32'h300, 4'hF, 1'b0, 32'h0BAD_F00D);
    step();
    reset = 1'b1;
    set_req(32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    exp_bus(32'h300, 4'hF, 1'b0, 32'h0BAD_F00D);
    step();
    last_rdata = 32'd0;
    exp_reset();
    cmp("rst_cyc_lit", {31'd0, wb_if.wb_cyc_o}, 32'd0);
    step();
    reset = 1'b0;
    wb_if.wb_ack_i = 1'b1; wb_if.wb_dat_i = 32'hFFFF_FFFF;
    exp_plain(1'b0);
    step();
    wb_if.wb_ack_i = 1'b0;
    exp_plain(1'b0);

`ifdef DBUS_WB_TIMEOUT_EN
    // silent slave: watchdog ends the access after TB_TMO BUS cycles
    run_access(32'h500, 32'd0, 1'b0, 1'b1, 3'd2, TB_TMO - 1, 1'b0, 1'b0, 1'b1, 32'h0, st);
    cmp("tmo_stall_cycles", st, TB_TMO + 1);
    cmp("tmo_err_lit", {31'd0, bus_err_o}, 32'd1);
    idle_cycle();
`endif

    // randomized accesses
    for (int i = 0; i < 200; i++) begin
      logic [2:0] op;
      logic [31:0] a;
      bit wr, rd;
      int kind;
      op = ops[($urandom_range(0, 9) < 9) ? $urandom_range(0, 4) : $urandom_range(5, 7)];
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (size_bytes(op) == 4) ? 2'd0 :
                                              (size_bytes(op) == 2) ? {a[1], 1'b0} : a[1:0];
      kind = $urandom_range(0, 2);
      wr = (kind != 0);
      rd = (kind != 1);
      run_access(a, $urandom, wr, rd, op, $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 1), 1'b0, $urandom, st);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
    e_chk = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_wb_master.md
Name: dbus_wb_master

Overview:
- Downstream neighbour of the rv32i core's data-memory port.
- Converts the core's MEM-stage request (mem_addr_mem, mem_wdata_mem, mem_write_mem, mem_read_mem, mem_op_mem) into a single Wishbone B4 classic master cycle.
- Returns aligned, sign/zero-extended load data on mem_rdata_mem.
- Holds the pipeline with stall_pipl until the bus cycle completes.

Parameters:
- TIMEOUT_CYCLES, 255, watchdog limit in clk cycles spent in BUS; used only with DBUS_WB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mem_addr_mem  in  32  byte address from core
- mem_wdata_mem  in  32  store data, right-aligned (byte/half in low bits)
- mem_write_mem  in  1  store request
- mem_read_mem  in  1  load request
- mem_op_mem  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- mem_rdata_mem  out  32  extended load data
- stall_pipl  out  1  freeze core pipeline
- wb_adr_o  out  32  word address; bits [1:0] forced to 0
- wb_dat_o  out  32  lane-shifted store data
- wb_dat_i  in  32  slave read data
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte lane selects
- wb_cyc_o  out  1  cycle valid
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error termination
- bus_err_o  out  1  one-cycle pulse: err (or timeout) terminated the access
- misaligned_o  out  1  one-cycle pulse: misaligned access rejected

Behaviour:
- Request: req = mem_read_mem | mem_write_mem. If both are high, it is treated as a write.
- FSM states:
  - IDLE:
    - req and aligned: latch adr, we, sel, shifted wdata, op, addr[1:0]; go to BUS.
    - req and misaligned: go to DONE with rdata 0 and pulse misaligned_o in DONE; no bus cycle.
  - BUS:
    - wb_cyc_o = wb_stb_o = 1; adr, we, sel, dat_o stable from the latched registers.
    - wb_ack_i: capture the extended read data (writes capture 0) and go to DONE.
    - wb_err_i (priority over ack when both high): rdata 0, bus_err_o pulses in DONE, go to DONE.
  - DONE:
    - cyc/stb low; mem_rdata_mem holds the captured value; go to IDLE unconditionally.
    - The request still present this cycle is the same instruction and is ignored.
- stall_pipl (combinational) = (state==IDLE & req) | (state==BUS). It is 0 in DONE, so the pipeline advances at the end of DONE.
- Minimum access latency with zero-wait ack is 3 cycles: IDLE-detect, BUS+ack, DONE. Each extra wait state adds 1 cycle.
- Back-to-back accesses: the next request is detected in IDLE on the cycle after DONE.
- Alignment:
  - Half access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
  - Unsupported funct3 (011, 110, 111) is treated as misaligned.
- wb_sel_o:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- wb_dat_o: byte data replicated on all 4 lanes; half data replicated on both halves; word data passed through.
- Load extraction:
  - Byte lane = wb_dat_i[8*addr[1:0] +: 8]; half = wb_dat_i[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- mem_rdata_mem keeps its last value in IDLE/BUS until the next capture.
- Reset values: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o 0; wb_sel_o 0; wb_adr_o 0; wb_dat_o 0; mem_rdata_mem 0; bus_err_o, misaligned_o 0.
- Reset mid-BUS: cyc/stb drop at that edge and the access is abandoned. A late ack arriving in IDLE is ignored.
- wb_ack_i / wb_err_i outside BUS are ignored.

Optional Feature:
- DBUS_WB_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entry to BUS and increments each cycle in BUS.
  - On reaching TIMEOUT_CYCLES without ack/err, the access terminates like wb_err_i: rdata 0, bus_err_o pulse, go to DONE.
- DBUS_WB_TIMEOUT_EN not defined: no counter; BUS waits indefinitely for ack/err.

Test Plan:
- LW addr 0x100, slave acks 1st BUS cycle with 0xDEADBEEF: sel=1111, stall high 2 cycles, mem_rdata_mem=0xDEADBEEF in DONE, total 3 cycles.
- LB addr 0x103, wb_dat_i=0x80FF_0000: sel=1000, rdata=0xFFFFFF80; LBU same access gives 0x00000080.
- SH addr 0x202, wdata=0x0000ABCD: we=1, sel=1100, wb_dat_o=0xABCDABCD, adr=0x200; ack after 3 wait states gives stall high 5 cycles.
- LW addr 0x101: no wb_cyc_o, misaligned_o pulses 1 cycle, rdata=0, stall released after 2 cycles.
- Slave asserts wb_err_i with ack on an SW: bus_err_o pulses, cyc drops next cycle; reset asserted mid-BUS forces cyc/stb=0 at next edge with all outputs at reset values.
- With DBUS_WB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks: bus_err_o pulses after 16 BUS cycles, FSM returns to IDLE.
